icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and instruction memory.
- Replaces the pass-through wiring of Instr_address_2IC, Instr1_fIC and Instr2_fIC.
- Serves hits from internal register arrays in the same cycle.
- On a miss, refills one 256-bit line over the iBlkRead / block_read_fIM handshake; IF stalls on Instr_valid_fIC low.

Parameters:
INDEX_BITS, 5, number of lines = 2**INDEX_BITS; line size fixed at 32 bytes (8 words); tag = addr[31:INDEX_BITS+5]

Ports:
CLK  input  1  clock
RESET  input  1  synchronous, active-high reset
Instr_address_2IC  input  32  fetch byte address from IF, word aligned
Instr1_fIC  output  32  instruction at Instr_address_2IC
Instr2_fIC  output  32  instruction at Instr_address_2IC+4
Instr_valid_fIC  output  1  Instr1_fIC is valid this cycle (hit)
Instr2_valid_fIC  output  1  Instr2_fIC is valid (hit, and +4 in the same line)
Invalidate  input  1  clear all valid bits (syscall / self-modifying code)
Instr_address_2IM  output  32  line-aligned refill address ({addr[31:5],5'b0})
iBlkRead  output  1  block read request
block_read_fIM  input  256  refill line; word i at bits [32i+31:32i], word 0 at lowest address
block_read_fIM_valid  input  1  refill data valid, single-cycle pulse

Behaviour:
- Decided: one clock CLK; RESET synchronous, active-high.
- Storage:
  - valid[2**INDEX_BITS]
  - tag[2**INDEX_BITS][32-INDEX_BITS-5]
  - data[2**INDEX_BITS][256]
- Address fields: index = addr[INDEX_BITS+4:5]; word = addr[4:2].
- Hit (combinational): valid[index] && tag[index]==addr tag.
  - Instr1_fIC = selected word.
  - Instr_valid_fIC=1.
  - Instr2 valid only if word!=7 and hit; otherwise Instr2_fIC=0 and Instr2_valid_fIC=0.
- On a miss, Instr1_fIC=0 and Instr_valid_fIC=0.
- FSM states:
  - IDLE: on a miss with no Invalidate, latch the line address into miss_addr and go to REFILL next edge.
  - REFILL: iBlkRead=1, Instr_address_2IM=miss_addr, both held stable until block_read_fIM_valid=1. On that edge, write data/tag/valid[miss index] and go to FILL_DONE.
  - FILL_DONE: one cycle, iBlkRead=0, outputs still report a miss. Return to IDLE, so the retried lookup hits. Minimum miss penalty is 3 cycles plus memory latency.
- Instr_address_2IC changing during REFILL: ignored. The latched refill completes; the next lookup uses the new address.
- Invalidate:
  - In IDLE or FILL_DONE: clears all valid bits on that edge. A miss detected in the same cycle does not start a refill; the lookup retries next cycle.
  - In REFILL: clears all valid bits and sets a drop flag. On block_read_fIM_valid the line is NOT installed (valid stays 0) and the FSM still goes to FILL_DONE. The drop flag clears in FILL_DONE.
- Conflict: a refill overwrites the resident line at the index; no write-back (read-only).
- block_read_fIM_valid outside REFILL: ignored.
- Instr_address_2IM in IDLE: equals the line-aligned Instr_address_2IC (don't-care to memory because iBlkRead=0).
- Reset values, applied at any state including mid-REFILL:
  - FSM=IDLE; all valid bits=0; drop flag=0; miss_addr=0.
  - iBlkRead=0; Instr_valid_fIC=0 (combinational consequence).
  - A block_read_fIM_valid arriving after reset is ignored.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds two outputs:
  - hit_count (32): increments on each cycle in IDLE with Instr_valid_fIC=1 and an address different from the previous cycle's hit address. Stalled repeats are not counted.
  - miss_count (32): increments on each IDLE->REFILL transition.
- Both counters reset to 0, wrap at 2**32, and are verilator public.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, addr 0x00400020, memory returns valid 4 cycles after iBlkRead.
  - iBlkRead rises 1 cycle after request, with Instr_address_2IM=0x00400020.
  - Line installed; Instr_valid_fIC=1 two cycles after the valid pulse; Instr1 = word 0 of the block.
- Hit, same line: addr 0x00400024 after the fill -> Instr_valid_fIC=1 same cycle, Instr1=word1, Instr2=word2, no iBlkRead.
- Line boundary: addr 0x0040003C -> Instr1=word7 valid, Instr2_valid_fIC=0, Instr2_fIC=0.
- Conflict eviction (INDEX_BITS=5): fill 0x00400000, then 0x00400400 (same index, different tag), then 0x00400000 -> three refills; the final data matches the first block.
- Invalidate in REFILL: Invalidate pulse 2 cycles into a refill -> block consumed, valid[index] stays 0, the following lookup misses and issues a new iBlkRead.
- Reset mid-refill: RESET while iBlkRead=1 -> next cycle iBlkRead=0, FSM IDLE, all lookups miss; a late block_read_fIM_valid installs nothing. With ICACHE_STATS_EN, after the cold-miss plus hit sequence: miss_count=1, hit_count=2.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The cache attaches through the slave modport; the IF stage and instruction
// memory (or a bench standing in for them) attach through the master modport.
interface icache_direct_if;
    logic [31:0]  Instr_address_2IC;
    logic [31:0]  Instr1_fIC;
    logic [31:0]  Instr2_fIC;
    logic         Instr_valid_fIC;
    logic         Instr2_valid_fIC;
    logic         Invalidate;
    logic [31:0]  Instr_address_2IM;
    logic         iBlkRead;
    logic [255:0] block_read_fIM;
    logic         block_read_fIM_valid;

    modport master (
        output Instr_address_2IC, Invalidate, block_read_fIM, block_read_fIM_valid,
        input  Instr1_fIC, Instr2_fIC, Instr_valid_fIC, Instr2_valid_fIC,
               Instr_address_2IM, iBlkRead
    );

    modport slave (
        input  Instr_address_2IC, Invalidate, block_read_fIM, block_read_fIM_valid,
        output Instr1_fIC, Instr2_fIC, Instr_valid_fIC, Instr2_valid_fIC,
               Instr_address_2IM, iBlkRead
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: 2**INDEX_BITS lines of 32 bytes.
// Hits are answered combinationally from the register arrays; a miss refills
// one 256-bit line over the iBlkRead / block_read_fIM handshake.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | lookups served; a miss latches its line and requests it
// S_REFILL    | iBlkRead held with the latched line address until data
// S_FILL_DONE | one settle cycle, still a miss, then lookup retries
module icache_direct #(
    parameter int INDEX_BITS = 5
) (
    input  logic           CLK,
    input  logic           RESET,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
`endif
);

    localparam int NLINES = 1 << INDEX_BITS;
    localparam int TAG_W  = 32 - INDEX_BITS - 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_FILL_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [NLINES-1:0]       r_valid;
    logic [TAG_W-1:0]        r_tag  [NLINES];
    logic [255:0]            r_data [NLINES];
    logic [31:0]             r_miss_addr;
    logic                    r_drop;

    logic [31:0]             w_addr;
    logic [INDEX_BITS-1:0]   w_index;
    logic [2:0]              w_word;
    logic [2:0]              w_word_nxt;
    logic [TAG_W-1:0]        w_tag;
    logic [31:0]             w_line_addr;
    logic                    w_hit;
    logic [255:0]            w_line;
    logic [31:0]             w_word1;
    logic [31:0]             w_word2;
    logic                    w_start_miss;
    logic                    w_fill;
    logic                    w_install;
    logic [INDEX_BITS-1:0]   w_fill_idx;
    logic                    w_unused;

    // Split the fetch address and look the line up; only IDLE reports hits.
    always_comb begin
        w_addr      = bus.Instr_address_2IC;
        w_index     = w_addr[INDEX_BITS+4:5];
        w_word      = w_addr[4:2];
        w_word_nxt  = w_word + 3'd1;
        w_tag       = w_addr[31:INDEX_BITS+5];
        w_line_addr = {w_addr[31:5], 5'b0};
        w_unused    = ^w_addr[1:0];
        w_line      = r_data[w_index];
        w_hit       = (r_state == S_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);
        w_word1     = w_line[{w_word, 5'b0} +: 32];
        w_word2     = w_line[{w_word_nxt, 5'b0} +: 32];
        w_fill_idx  = r_miss_addr[INDEX_BITS+4:5];
    end

    // Fetch-side outputs; the second word is only offered when it is in the same line.
    always_comb begin
        bus.Instr_valid_fIC  = w_hit;
        bus.Instr1_fIC       = w_hit ? w_word1 : 32'd0;
        bus.Instr2_valid_fIC = w_hit && (w_word != 3'd7);
        bus.Instr2_fIC       = (w_hit && (w_word != 3'd7)) ? w_word2 : 32'd0;
    end

    // Next-state logic and memory-side request.
    always_comb begin
        w_next                = r_state;
        w_start_miss          = 1'b0;
        w_fill                = 1'b0;
        bus.iBlkRead          = 1'b0;
        bus.Instr_address_2IM = w_line_addr;
        case (r_state)
            S_IDLE: begin
                if (!w_hit && !bus.Invalidate) begin
                    w_start_miss = 1'b1;
                    w_next       = S_REFILL;
                end
            end
            S_REFILL: begin
                bus.iBlkRead          = 1'b1;
                bus.Instr_address_2IM = r_miss_addr;
                if (bus.block_read_fIM_valid) begin
                    w_fill = 1'b1;
                    w_next = S_FILL_DONE;
                end
            end
            S_FILL_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // An invalidate seen during the refill (earlier or on the data cycle) discards the line.
        w_install = w_fill && !r_drop && !bus.Invalidate;
    end

    // State, valid bits, miss address and drop flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_miss_addr <= 32'd0;
            r_drop      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_miss) begin
                r_miss_addr <= w_line_addr;
            end
            if (bus.Invalidate) begin
                r_valid <= '0;
            end else if (w_install) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
            if (r_state == S_FILL_DONE) begin
                r_drop <= 1'b0;
            end else if ((r_state == S_REFILL) && bus.Invalidate) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate them.
    always_ff @(posedge CLK) begin
        if (!RESET && w_install) begin
            r_tag[w_fill_idx]  <= r_miss_addr[31:INDEX_BITS+5];
            r_data[w_fill_idx] <= bus.block_read_fIM;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_prev_hit;
    logic [31:0] r_prev_hit_addr;

    // Count new hits (a stalled repeat of the same hit is not new) and refill starts.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hit_count     <= 32'd0;
            r_miss_count    <= 32'd0;
            r_prev_hit      <= 1'b0;
            r_prev_hit_addr <= 32'd0;
        end else begin
            if (w_start_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (w_hit && !(r_prev_hit && (r_prev_hit_addr == w_addr))) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            r_prev_hit      <= w_hit;
            r_prev_hit_addr <= w_addr;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
